// File: rtl/gesture_vision_pkg.sv
// Shared definitions for the vision pipeline: image geometry defaults,
// stream-controller FSM encoding and the layout of the pixel tag word.
package gesture_vision_pkg;

    localparam int IMG_W_DEF      = 320;
    localparam int IMG_H_DEF      = 240;
    localparam int CONV_LAT_DEF   = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int PIX_W  = 16;          // RGB565
    localparam int CH_W   = 8;           // one Y/Cb/Cr channel
    localparam int YCC_W  = 3 * CH_W;

    // Tag word, LSB first: eof, eol, sof, row, col
    localparam int FLAG_W  = 3;
    localparam int EOF_OFS = 0;
    localparam int EOL_OFS = 1;
    localparam int SOF_OFS = 2;
    localparam int ROW_OFS = FLAG_W;

    function automatic int col_ofs(input int row_w);
        return FLAG_W + row_w;
    endfunction

    function automatic int tag_w(input int col_w, input int row_w);
        return col_w + row_w + FLAG_W;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DRAIN    = 2'd3
    } state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is visible on dout whenever
// empty is low; writes land on the clock edge.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign do_pop = pop & (count_q != '0);
    assign dout   = mem_q[rd_ptr_q];
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;

    // Pointer and occupancy update; push+pop together keeps the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // The credit scheme upstream must never let a push hit a full FIFO
            assert (!(push && full));
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ycbcr_stream_ctrl.sv
// Feeds RGB565 pixels into a stall-less external converter, carries the
// position tags alongside it, and parks results in a FIFO. Pixels are only
// accepted while a FIFO slot is reserved for them, so backpressure on the
// output can never lose a converter result.
module ycbcr_stream_ctrl
    import gesture_vision_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int CONV_LAT   = CONV_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int COL_W      = $clog2(IMG_W),
    parameter int ROW_W      = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [PIX_W-1:0] s_pix,
    input  logic             s_sof,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PIX_W-1:0] conv_rgb565,
    output logic             conv_valid_in,
    input  logic [CH_W-1:0]  conv_y,
    input  logic [CH_W-1:0]  conv_cb,
    input  logic [CH_W-1:0]  conv_cr,
    input  logic             conv_valid_out,
    output logic [CH_W-1:0]  m_y,
    output logic [CH_W-1:0]  m_cb,
    output logic [CH_W-1:0]  m_cr,
    output logic [COL_W-1:0] m_col,
    output logic [ROW_W-1:0] m_row,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_done,
    output logic             err_sync
);

    localparam int TAG_W   = tag_w(COL_W, ROW_W);
    localparam int COL_OFS = col_ofs(ROW_W);
    localparam int ENT_W   = YCC_W + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    // Every in-flight pixel needs a guaranteed FIFO slot, plus one for the head being popped
    if (FIFO_DEPTH < CONV_LAT + 2) begin : g_bad_depth
        $error("ycbcr_stream_ctrl: FIFO_DEPTH must be >= CONV_LAT+2");
    end

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CONV_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [TAG_W-1:0]   tag_pipe_q [CONV_LAT];
    logic [TAG_W-1:0]   tag_pipe_d [CONV_LAT];
    logic               err_sync_q, err_sync_d;
    logic               frame_done_q, frame_done_d;

    logic               has_credit, accept, issue, pop, drain_done;
    logic [COL_W-1:0]   iss_col;
    logic [ROW_W-1:0]   iss_row;
    logic               iss_sof, iss_eol, iss_eof;
    logic [TAG_W-1:0]   iss_tag;
    logic [ENT_W-1:0]   fifo_din, fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;

    // Credit: FIFO slots not already occupied or promised to in-flight pixels
    assign has_credit = !fifo_full &&
                        (({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_C);
    assign s_ready    = ((state_q == ST_WAIT_SOF) || (state_q == ST_ACTIVE)) && has_credit;
    assign accept     = s_valid && s_ready;
    // While hunting for a frame start, non-sof pixels are swallowed without issue
    assign issue         = accept && ((state_q == ST_ACTIVE) || s_sof);
    assign conv_valid_in = issue;
    assign conv_rgb565   = issue ? s_pix : '0;

    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    // Frame is done once nothing is in the converter and this cycle's pop empties the FIFO
    assign drain_done = (inflight_q == '0) && !conv_valid_out &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

    // Tag for the pixel being issued; a sof pixel always restarts at (0,0)
    always_comb begin
        iss_col = s_sof ? '0 : col_q;
        iss_row = s_sof ? '0 : row_q;
        iss_eol = (iss_col == COL_W'(IMG_W - 1));
        iss_eof = iss_eol && (iss_row == ROW_W'(IMG_H - 1));
        iss_sof = (iss_col == '0) && (iss_row == '0);
        iss_tag = {iss_col, iss_row, iss_sof, iss_eol, iss_eof};
    end

    // Frame sequencing, position counters and status pulses
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        err_sync_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF, ST_ACTIVE: begin
                if (issue) begin
                    state_d = ST_ACTIVE;
                    if (iss_eof) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = ST_DRAIN;
                    end else if (iss_eol) begin
                        col_d = '0;
                        row_d = iss_row + 1'b1;
                    end else begin
                        col_d = iss_col + 1'b1;
                        row_d = iss_row;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    frame_done_d = 1'b1;
                    state_d      = enable ? ST_WAIT_SOF : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Unexpected frame start, or converter output not lining up with our tags
        if ((state_q == ST_ACTIVE) && accept && s_sof) err_sync_d = 1'b1;
        if (vld_pipe_q[CONV_LAT-1] != conv_valid_out) err_sync_d = 1'b1;
    end

    // Tag shift register mirroring the converter pipeline, advanced every cycle
    always_comb begin
        vld_pipe_d[0] = issue;
        tag_pipe_d[0] = issue ? iss_tag : '0;
        for (int i = 1; i < CONV_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    // In-flight count; issue and return in the same cycle cancel out
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !conv_valid_out)
            inflight_d = inflight_q + 1'b1;
        else if (!issue && conv_valid_out && (inflight_q != '0))
            inflight_d = inflight_q - 1'b1;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            inflight_q   <= '0;
            vld_pipe_q   <= '0;
            err_sync_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < CONV_LAT; i++) tag_pipe_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            inflight_q   <= inflight_d;
            vld_pipe_q   <= vld_pipe_d;
            err_sync_q   <= err_sync_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < CONV_LAT; i++) tag_pipe_q[i] <= tag_pipe_d[i];
        end
    end

    assign err_sync   = err_sync_q;
    assign frame_done = frame_done_q;

    // Any converter result is stored, even if its tag slot was empty
    assign fifo_din = {conv_y, conv_cb, conv_cr, tag_pipe_q[CONV_LAT-1]};

    sync_fifo_fwft #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (conv_valid_out),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_y   = fifo_dout[TAG_W + 2*CH_W +: CH_W];
    assign m_cb  = fifo_dout[TAG_W + CH_W   +: CH_W];
    assign m_cr  = fifo_dout[TAG_W          +: CH_W];
    assign m_col = fifo_dout[COL_OFS +: COL_W];
    assign m_row = fifo_dout[ROW_OFS +: ROW_W];
    assign m_sof = fifo_dout[SOF_OFS];
    assign m_eol = fifo_dout[EOL_OFS];
    assign m_eof = fifo_dout[EOF_OFS];

endmodule

// File: tb/tb_ycbcr_stream_ctrl.sv
// Directed bench for ycbcr_stream_ctrl on a 4x2 image with a behavioural
// two-stage RGB565->YCbCr converter attached.
module tb_ycbcr_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] s_pix = '0;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] conv_rgb565;
    logic        conv_valid_in;
    logic [7:0]  conv_y, conv_cb, conv_cr;
    logic        conv_valid_out;
    logic [7:0]  m_y, m_cb, m_cr;
    logic [1:0]  m_col;
    logic [0:0]  m_row;
    logic        m_sof, m_eol, m_eof, m_valid;
    logic        m_ready = 1'b0;
    logic        frame_done, err_sync;

    always #5 clk = ~clk;

    ycbcr_stream_ctrl #(.IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_pix(s_pix), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
        .conv_rgb565(conv_rgb565), .conv_valid_in(conv_valid_in),
        .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr),
        .conv_valid_out(conv_valid_out),
        .m_y(m_y), .m_cb(m_cb), .m_cr(m_cr), .m_col(m_col), .m_row(m_row),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .m_valid(m_valid),
        .m_ready(m_ready), .frame_done(frame_done), .err_sync(err_sync)
    );

    // BT.601 studio-range conversion with 8-bit fixed-point coefficients
    function automatic logic [23:0] rgb2ycc(input logic [15:0] p);
        int r, g, b, y, cb, cr;
        r  = {p[15:11], p[15:13]};
        g  = {p[10:5],  p[10:9]};
        b  = {p[4:0],   p[4:2]};
        y  = 16  + ((66*r + 129*g + 25*b + 128) >>> 8);
        cb = 128 + ((-38*r - 74*g + 112*b + 128) >>> 8);
        cr = 128 + ((112*r - 94*g - 18*b + 128) >>> 8);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    // Converter model: two register stages, shares rst_n with the controller
    logic [23:0] cv1_q;
    logic        cv1_v;
    always @(posedge clk) begin
        if (!rst_n) begin
            cv1_v <= 1'b0; cv1_q <= '0; conv_valid_out <= 1'b0;
            conv_y <= '0; conv_cb <= '0; conv_cr <= '0;
        end else begin
            cv1_v <= conv_valid_in;
            cv1_q <= rgb2ycc(conv_rgb565);
            conv_valid_out <= cv1_v;
            {conv_y, conv_cb, conv_cr} <= cv1_q;
        end
    end

    typedef struct packed {
        logic [23:0] ycc;
        logic [5:0]  tag;   // {col, row, sof, eol, eof}
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc_n = 0, pops = 0, accepts = 0, fd_cnt = 0, err_cnt = 0, stalls = 0;
    int pop_mark = 0, first_pop_cyc = 0, last_pop_cyc = 0, fd_cyc = 0, acc_cyc = 0;

    function automatic exp_t mk_exp(input logic [15:0] pix, input int col, input int row);
        exp_t e;
        logic sof, eol, eof;
        sof = (col == 0) && (row == 0);
        eol = (col == 3);
        eof = eol && (row == 1);
        e.ycc = rgb2ycc(pix);
        e.tag = {col[1:0], row[0], sof, eol, eof};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (pops, accepts, pulses), then advance one clock
    task automatic clk1();
        exp_t e;
        #1;
        if (m_valid && m_ready) begin
            chk("pop_has_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_ycc", {m_y, m_cb, m_cr}, e.ycc);
                chk("pop_tag", {m_col, m_row, m_sof, m_eol, m_eof}, e.tag);
            end
            if (pops == pop_mark) first_pop_cyc = cyc_n;
            last_pop_cyc = cyc_n;
            pops++;
        end
        if (s_valid && s_ready) accepts++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc_n; end
        if (err_sync) err_cnt++;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Present one pixel and hold it until accepted (bounded)
    task automatic send(input logic [15:0] pix, input logic sof, input logic iss,
                        input int col, input int row);
        int n;
        s_pix = pix; s_sof = sof; s_valid = 1'b1;
        n = 0;
        #1;
        while (!s_ready && n < 40) begin
            clk1();
            n++;
        end
        stalls += n;
        chk("s_ready_for_pixel", s_ready, 1);
        chk("conv_valid_in", conv_valid_in, iss);
        if (iss) begin
            chk("conv_rgb565", conv_rgb565, pix);
            exp_q.push_back(mk_exp(pix, col, row));
        end
        acc_cyc = cyc_n;
        clk1();
    endtask

    task automatic run_until_fd(input string tag);
        int n, f0;
        n = 0; f0 = fd_cnt;
        while (fd_cnt == f0 && n < 40) begin
            clk1();
            n++;
        end
        chk(tag, 64'(fd_cnt - f0), 1);
    endtask

    logic [15:0] pix4 [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000,
                              16'hFFFF, 16'h8410, 16'h1234, 16'hABCD};
    int a0, p0, f0, e0, s0, acc_first;

    initial begin
        // ---- 1: reset in the middle of a frame
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; enable = 1'b1;
        clk1();
        send(16'h1111, 1'b1, 1'b1, 0, 0);
        send(16'h2222, 1'b0, 1'b1, 1, 0);
        send(16'h3333, 1'b0, 1'b1, 2, 0);
        s_pix = 16'hAAAA; s_sof = 1'b0; s_valid = 1'b1;
        rst_n = 1'b0;
        repeat (3) clk1();
        exp_q.delete();
        #1;
        chk("rst_outputs_zero",
            {s_ready, conv_valid_in, conv_rgb565, m_y, m_cb, m_cr, m_col, m_row,
             m_sof, m_eol, m_eof, frame_done, err_sync}, 0);
        chk("rst_fifo_empty", m_valid, 0);
        s_valid = 1'b0; rst_n = 1'b1; enable = 1'b1;
        #1;
        chk("idle_s_ready", s_ready, 0);
        clk1();
        chk("wait_sof_s_ready", s_ready, 1);

        // ---- 2: non-sof pixels are dropped while waiting for a frame start
        for (int i = 0; i < 3; i++) send(16'h1234, 1'b0, 1'b0, 0, 0);
        s_valid = 1'b0;
        #1;
        chk("drop_no_m_valid", m_valid, 0);
        clk1();
        chk("drop_no_m_valid_later", m_valid, 0);

        // ---- 3: white sof pixel, latency to m_valid
        send(16'hFFFF, 1'b1, 1'b1, 0, 0);
        s_valid = 1'b0;
        #1;
        chk("lat_t1_m_valid", m_valid, 0);
        clk1();
        chk("lat_t2_m_valid", m_valid, 0);
        clk1();
        chk("lat_t3_m_valid", m_valid, 1);
        chk("white_ycc", {m_y, m_cb, m_cr}, {8'd235, 8'd128, 8'd128});
        chk("white_tag", {m_col, m_row, m_sof, m_eol, m_eof}, 6'b00_0_100);
        m_ready = 1'b1;
        for (int i = 1; i < 8; i++) send(16'h0100 + 16'(i), 1'b0, 1'b1, i % 4, i / 4);
        s_valid = 1'b0;
        run_until_fd("t3_frame_done");

        // ---- 4: full frame back-to-back with m_ready held high
        p0 = pops; s0 = stalls; pop_mark = pops;
        for (int i = 0; i < 8; i++) begin
            send(pix4[i], (i == 0), 1'b1, i % 4, i / 4);
            if (i == 0) acc_first = acc_cyc;
        end
        s_valid = 1'b0;
        run_until_fd("t4_frame_done");
        chk("t4_pops", 64'(pops - p0), 8);
        chk("t4_consecutive", 64'(last_pop_cyc - first_pop_cyc), 7);
        chk("t4_latency", 64'(first_pop_cyc - acc_first), 3);
        chk("t4_fd_after_last_pop", 64'(fd_cyc - last_pop_cyc), 1);
        chk("t4_no_stalls", 64'(stalls - s0), 0);

        // ---- 5: output blocked, credits limit acceptance to FIFO depth
        m_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i), (i == 0), 1'b1, i, 0);
        s_pix = 16'h5004; s_sof = 1'b0; s_valid = 1'b1;
        repeat (6) clk1();
        chk("t5_accepts", 64'(accepts - a0), 4);
        chk("t5_s_ready_blocked", s_ready, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        p0 = pops;
        for (int n = 0; n < 20 && (pops - p0) < 4; n++) clk1();
        chk("t5_pops", 64'(pops - p0), 4);
        #1;
        chk("t5_s_ready_back", s_ready, 1);
        for (int i = 4; i < 8; i++) send(16'h5000 + 16'(i), 1'b0, 1'b1, i % 4, i / 4);
        s_valid = 1'b0;
        run_until_fd("t5_frame_done");

        // ---- 6: sof arrives on the 4th pixel of a frame
        f0 = fd_cnt; e0 = err_cnt;
        send(16'h6000, 1'b1, 1'b1, 0, 0);
        send(16'h6001, 1'b0, 1'b1, 1, 0);
        send(16'h6002, 1'b0, 1'b1, 2, 0);
        send(16'h6003, 1'b1, 1'b1, 0, 0);
        s_valid = 1'b0;
        #1;
        chk("t6_err_sync_pulse", err_sync, 1);
        clk1();
        chk("t6_err_sync_one_cycle", err_sync, 0);
        for (int i = 1; i < 8; i++) send(16'h6100 + 16'(i), 1'b0, 1'b1, i % 4, i / 4);
        s_valid = 1'b0;
        run_until_fd("t6_frame_done");
        chk("t6_one_frame_done", 64'(fd_cnt - f0), 1);
        chk("t6_one_err", 64'(err_cnt - e0), 1);

        chk("total_err_pulses", 64'(err_cnt), 1);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        chk("final_m_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
